seven_segment_manager: RTL and testbench

AHB-Lite slave that takes display data written by the processor and drives the cycle computer's 4-digit multiplexed seven-segment display. It is the output-side counterpart of the button input block and sits on the same AHB bus. Software writes digit codes into staging registers, then commits them. The block copies a commit into its shadow registers only at a frame boundary, so the display never tears. The block scans the digits continuously with no further software involvement.

---
 rtl/seg_pkg.sv | 51 +++++
 rtl/seven_segment_manager_if.sv | 30 +++
 rtl/seg_scan_counter.sv | 44 ++++
 rtl/seven_segment_manager.sv | 170 +++++++++++++++++
 tb/tb_seven_segment_manager.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display manager:
//   - AHB register word offsets (HADDR[4:2])
//   - digit register field layout and widths
//   - hex-to-segment lookup table and the hex7seg() helper
// No ports (package).
// ---------------------------------------------------------------------------
package seg_pkg;

  // Register map, word offsets decoded from HADDR[4:2]
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT0   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT1   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT2   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT3   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_COMMIT   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_UNMAPPED = 3'd7;

  // Display geometry and field widths
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;
  localparam int HEX_W      = 4;
  localparam int DIGIT_W    = 6;
  localparam int SEG_W      = 7;
  localparam int DIV_W      = 10;

  // One digit register: {dp, blank, value} occupies bits [5], [4], [3:0]
  typedef struct packed {
    logic             dp;
    logic             blank;
    logic [HEX_W-1:0] value;
  } digit_t;

  localparam digit_t DIGIT_RESET = digit_t'(6'b010000);

  // Segment patterns {g,f,e,d,c,b,a}, active-high; entry 0 sits in the LSBs
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [SEG_W-1:0] hex7seg(input logic [HEX_W-1:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seven_segment_manager_if.sv
// ---------------------------------------------------------------------------
// seven_segment_manager_if
// AHB-Lite slave-side bundle for the seven-segment display manager.
//   master modport: drives HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS;
//                   receives HRDATA, HREADYOUT
//   slave  modport: the reverse
// ---------------------------------------------------------------------------
interface seven_segment_manager_if;

  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
    output HRDATA, HREADYOUT
  );

endinterface

// File: rtl/seg_scan_counter.sv
// ---------------------------------------------------------------------------
// seg_scan_counter
// Free-running digit scan timing for the multiplexed display.
//   HCLK        in   system clock
//   HRESETn     in   asynchronous active-low reset
//   div_count   out  position inside the current digit slot, 0..SCAN_DIV-1
//   digit_idx   out  digit currently being scanned, 0..3
//   frame_tick  out  high in the last cycle of a frame; the following edge
//                    wraps digit_idx from 3 to 0 (the frame boundary edge)
// SCAN_DIV is the number of HCLK cycles per digit slot, legal range 2..1023.
// ---------------------------------------------------------------------------
module seg_scan_counter
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  output logic [DIV_W-1:0] div_count,
  output logic [IDX_W-1:0] digit_idx,
  output logic             frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic slot_end;

  assign slot_end   = (div_count == DIV_LAST);
  assign frame_tick = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  // Slot divider and digit index; digit_idx wraps naturally from 3 to 0
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_count <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      div_count <= '0;
      digit_idx <= digit_idx + IDX_W'(1);
    end else begin
      div_count <= div_count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seven_segment_manager.sv
// ---------------------------------------------------------------------------
// seven_segment_manager
// AHB-Lite slave that stages digit codes written by software and drives a
// 4-digit multiplexed seven-segment display. A COMMIT write marks the staged
// digits pending; they are copied to the shadow registers only at a frame
// boundary so a frame never shows a mix of old and new digits.
//   HCLK      in   system clock
//   HRESETn   in   asynchronous active-low reset
//   bus       --   AHB-Lite slave modport (HADDR[4:2] decoded, zero wait)
//   Seg       out  segments {g,f,e,d,c,b,a}, active-high, registered
//   DP        out  decimal point, active-high, registered
//   nDigit    out  digit enables, active-low, nDigit[0] = rightmost digit
// Register map: 0..3 DIGITn, 4 CTRL, 5 COMMIT (wo), 6 STATUS (ro), 7 unmapped.
// ---------------------------------------------------------------------------
module seven_segment_manager
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  seven_segment_manager_if.slave bus,
  output logic [SEG_W-1:0]      Seg,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] nDigit
);

  logic [DIV_W-1:0]      div_count;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_tick;

  logic                  access;
  logic                  write_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic                  commit_wr;

  digit_t                stage  [NUM_DIGITS];
  digit_t                shadow [NUM_DIGITS];
  logic                  enable;
  logic                  pending;

  logic [31:0]           hrdata;
  digit_t                active_digit;
  logic [SEG_W-1:0]      seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] ndigit_nxt;

  // Bus fields this slave never looks at (word-only, 8 registers, 6-bit data)
  logic                  unused_bus;
  assign unused_bus = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0],
                        bus.HWDATA[31:DIGIT_W]};

  seg_scan_counter #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .div_count  (div_count),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  assign access        = bus.HSEL && bus.HREADY && (bus.HTRANS != 2'b00);
  assign commit_wr     = write_reg && (addr_reg == ADDR_COMMIT);
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRDATA    = hrdata;

  // Address phase capture; idle cycles park on the unmapped offset so the
  // read mux returns zero and no write can fire
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_reg <= 1'b0;
      addr_reg  <= ADDR_UNMAPPED;
    end else if (access) begin
      write_reg <= bus.HWRITE;
      addr_reg  <= bus.HADDR[4:2];
    end else begin
      write_reg <= 1'b0;
      addr_reg  <= ADDR_UNMAPPED;
    end
  end

  // Staging registers and CTRL, written at the end of the data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        stage[i] <= DIGIT_RESET;
      end
      enable <= 1'b0;
    end else if (write_reg) begin
      case (addr_reg)
        ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3:
          stage[addr_reg[1:0]] <= digit_t'(bus.HWDATA[DIGIT_W-1:0]);
        ADDR_CTRL:
          enable <= bus.HWDATA[0];
        default: ;
      endcase
    end
  end

  // A commit landing on the boundary edge takes priority, so the request
  // is kept for the next frame rather than lost
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pending <= 1'b0;
    end else if (commit_wr) begin
      pending <= 1'b1;
    end else if (frame_tick) begin
      pending <= 1'b0;
    end
  end

  // Shadow copy at the frame boundary; uses pre-edge staging values, so a
  // digit write on the boundary edge waits for the next commit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= DIGIT_RESET;
      end
    end else if (frame_tick && pending) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= stage[i];
      end
    end
  end

  // Read data mux, driven straight from the registered address
  always_comb begin
    hrdata = '0;
    case (addr_reg)
      ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3:
        hrdata = {{(32-DIGIT_W){1'b0}}, stage[addr_reg[1:0]]};
      ADDR_CTRL:
        hrdata = {31'b0, enable};
      ADDR_STATUS:
        hrdata = {31'b0, pending};
      default:
        hrdata = '0;
    endcase
  end

  // Digit decode; slot cycle 0 is kept dark to avoid ghosting between digits
  always_comb begin
    active_digit = shadow[digit_idx];
    seg_nxt      = '0;
    dp_nxt       = 1'b0;
    ndigit_nxt   = '1;
    if (enable && (div_count != '0)) begin
      ndigit_nxt = ~(NUM_DIGITS'(1) << digit_idx);
      if (!active_digit.blank) begin
        seg_nxt = hex7seg(active_digit.value);
        dp_nxt  = active_digit.dp;
      end
    end
  end

  // Registered display outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      Seg    <= '0;
      DP     <= 1'b0;
      nDigit <= '1;
    end else begin
      Seg    <= seg_nxt;
      DP     <= dp_nxt;
      nDigit <= ndigit_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_manager.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_manager
// Directed bench for seven_segment_manager with SCAN_DIV = 4 (16-cycle frame).
// cyc counts HCLK edges since reset release; the scan position after edge n
// is slot cycle n%4 of digit (n/4)%4, and outputs show the position one
// edge earlier.
// ---------------------------------------------------------------------------
module tb_seven_segment_manager;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int NVEC     = 24;

  typedef struct packed {
    logic        wr;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [6:0]  Seg;
  logic        DP;
  logic [3:0]  nDigit;

  int          cyc;
  int          tests_run = 0;
  int          tests_failed = 0;
  vec_t        vecs [NVEC];
  logic [31:0] rd;
  int          n, b, m;

  seven_segment_manager_if bus ();

  seven_segment_manager #(
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .Seg     (Seg),
    .DP      (DP),
    .nDigit  (nDigit)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expN,
                             input logic [6:0] expSeg, input logic expDp);
    checkVal({name, ".nDigit"}, 32'(nDigit), 32'(expN));
    checkVal({name, ".Seg"},    32'(Seg),    32'(expSeg));
    checkVal({name, ".DP"},     32'(DP),     32'(expDp));
  endtask

  // One AHB transfer, started at #1 after an edge; returns #1 after the edge
  // that completes it (reads: data phase sampled, writes: write committed)
  task automatic applyStimulus(input logic wr, input logic [2:0] off,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HSIZE  = 3'b010;
    bus.HADDR  = {27'b0, off, 2'b00};
    @(posedge HCLK); #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HWDATA = wr ? wdata : 32'h0;
    rdata      = bus.HRDATA;
    if (wr) begin
      @(posedge HCLK); #1;
      rdata = 32'h0;
    end
  endtask

  task automatic waitUntil(input int target);
    int guard = 0;
    while (cyc < target && guard < 4000) begin
      @(posedge HCLK); #1;
      guard++;
    end
    if (cyc != target) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_cycle: got %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic alignTo(input int slot);
    int guard = 0;
    while ((cyc % FRAME) != slot && guard < 64) begin
      @(posedge HCLK); #1;
      guard++;
    end
    if ((cyc % FRAME) != slot) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL align: got %0d, expected %0d", cyc % FRAME, slot);
    end
  endtask

  function automatic int nextBoundary(input int c);
    return ((c / FRAME) + 1) * FRAME;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 32'h0,        32'h10};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,        32'h10};
    vecs[2]  = '{1'b0, 3'd2, 32'h0,        32'h10};
    vecs[3]  = '{1'b0, 3'd3, 32'h0,        32'h10};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 3'd6, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 3'd7, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 3'd0, 32'h08,       32'h0};
    vecs[9]  = '{1'b1, 3'd1, 32'h21,       32'h0};
    vecs[10] = '{1'b1, 3'd2, 32'hFFFFFF3F, 32'h0};
    vecs[11] = '{1'b1, 3'd3, 32'h1A,       32'h0};
    vecs[12] = '{1'b0, 3'd0, 32'h0,        32'h08};
    vecs[13] = '{1'b0, 3'd1, 32'h0,        32'h21};
    vecs[14] = '{1'b0, 3'd2, 32'h0,        32'h3F};
    vecs[15] = '{1'b0, 3'd3, 32'h0,        32'h1A};
    vecs[16] = '{1'b1, 3'd4, 32'h1,        32'h0};
    vecs[17] = '{1'b0, 3'd4, 32'h0,        32'h1};
    vecs[18] = '{1'b1, 3'd7, 32'hFF,       32'h0};
    vecs[19] = '{1'b0, 3'd7, 32'h0,        32'h0};
    vecs[20] = '{1'b1, 3'd6, 32'h1,        32'h0};
    vecs[21] = '{1'b0, 3'd6, 32'h0,        32'h0};
    vecs[22] = '{1'b1, 3'd2, 32'h10,       32'h0};
    vecs[23] = '{1'b1, 3'd3, 32'h0A,       32'h0};

    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HREADY = 1'b1;
    bus.HSIZE  = 3'b010;
    bus.HADDR  = 32'h0;
    bus.HWDATA = 32'h0;

    // Reset state while held in reset
    repeat (3) @(posedge HCLK);
    #1;
    checkOutput("in_reset", 4'b1111, 7'h00, 1'b0);
    checkVal("in_reset.HRDATA", bus.HRDATA, 32'h0);
    checkVal("HREADYOUT", 32'(bus.HREADYOUT), 32'h1);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    checkOutput("post_reset", 4'b1111, 7'h00, 1'b0);

    // Register file vectors
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].off, vecs[i].wdata, rd);
      if (!vecs[i].wr)
        checkVal($sformatf("reg_vec%0d_off%0d", i, vecs[i].off), rd, vecs[i].exp);
    end

    // Basic display: DIGIT0=8, DIGIT1=1+dp, DIGIT2 blank, DIGIT3=A
    alignTo(2);
    applyStimulus(1'b1, 3'd5, 32'h1, rd);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("status_after_commit", rd, 32'h1);
    n = nextBoundary(cyc);
    waitUntil(n - 2);  checkOutput("pre_boundary", 4'b0111, 7'h00, 1'b0);
    waitUntil(n + 1);  checkOutput("slot0_ghost", 4'b1111, 7'h00, 1'b0);
    waitUntil(n + 2);  checkOutput("slot0_a",     4'b1110, 7'h7F, 1'b0);
    waitUntil(n + 4);  checkOutput("slot0_b",     4'b1110, 7'h7F, 1'b0);
    waitUntil(n + 5);  checkOutput("slot1_ghost", 4'b1111, 7'h00, 1'b0);
    waitUntil(n + 6);  checkOutput("slot1",       4'b1101, 7'h06, 1'b1);
    waitUntil(n + 10); checkOutput("slot2_blank", 4'b1011, 7'h00, 1'b0);
    waitUntil(n + 14); checkOutput("slot3",       4'b0111, 7'h77, 1'b0);
    waitUntil(n + 17); checkOutput("f2_ghost",    4'b1111, 7'h00, 1'b0);
    waitUntil(n + 18); checkOutput("f2_slot0",    4'b1110, 7'h7F, 1'b0);

    // Tear-free: uncommitted DIGIT0 rewrite must not show for 10 frames
    applyStimulus(1'b1, 3'd0, 32'h03, rd);
    for (int f = 2; f < 12; f++) begin
      waitUntil(n + f * FRAME + 3);
      checkOutput($sformatf("hold_f%0d", f), 4'b1110, 7'h7F, 1'b0);
    end
    alignTo(2);
    applyStimulus(1'b1, 3'd5, 32'h1, rd);
    b = nextBoundary(cyc);
    waitUntil(b - 2);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("status_before_boundary", rd, 32'h1);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("status_after_boundary", rd, 32'h0);
    waitUntil(b + 2);  checkOutput("commit_3", 4'b1110, 7'h4F, 1'b0);

    // Commit on the boundary edge, then a digit write on the boundary edge
    alignTo(2);
    applyStimulus(1'b1, 3'd0, 32'h05, rd);
    applyStimulus(1'b1, 3'd5, 32'h1, rd);
    alignTo(14);
    applyStimulus(1'b1, 3'd5, 32'h1, rd);
    m = cyc;
    checkVal("commit_on_boundary_cycle", 32'(m % FRAME), 32'h0);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("status_commit_on_boundary", rd, 32'h1);
    waitUntil(m + 2);  checkOutput("cob_shadow_5", 4'b1110, 7'h6D, 1'b0);
    alignTo(14);
    applyStimulus(1'b1, 3'd0, 32'h06, rd);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("status_consumed", rd, 32'h0);
    waitUntil(m + 18); checkOutput("dw_on_boundary", 4'b1110, 7'h6D, 1'b0);
    waitUntil(m + 34); checkOutput("dw_not_taken",   4'b1110, 7'h6D, 1'b0);
    alignTo(14);
    applyStimulus(1'b1, 3'd5, 32'h1, rd);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("status_commit_idle_boundary", rd, 32'h1);
    waitUntil(m + 50); checkOutput("cob_no_update", 4'b1110, 7'h6D, 1'b0);
    waitUntil(m + 66); checkOutput("cob_next_frame", 4'b1110, 7'h7D, 1'b0);

    // Disabled: dark display, commits still complete
    applyStimulus(1'b1, 3'd4, 32'h0, rd);
    for (int i = 0; i < FRAME; i++) begin
      @(posedge HCLK); #1;
      checkVal($sformatf("disabled_nDigit_%0d", i), 32'(nDigit), 32'hF);
      checkVal($sformatf("disabled_Seg_%0d", i), 32'(Seg), 32'h0);
    end
    applyStimulus(1'b1, 3'd2, 32'h2C, rd);
    applyStimulus(1'b1, 3'd5, 32'h1, rd);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("disabled_status_set", rd, 32'h1);
    b = nextBoundary(cyc);
    waitUntil(b + 1);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("disabled_status_clear", rd, 32'h0);
    applyStimulus(1'b0, 3'd7, 32'h0, rd);
    checkVal("unmapped_read", rd, 32'h0);

    // Asynchronous reset mid-scan with DigitIdx = 2
    applyStimulus(1'b1, 3'd4, 32'h1, rd);
    alignTo(9);
    applyStimulus(1'b0, 3'd2, 32'h0, rd);
    checkVal("digit2_readback", rd, 32'h2C);
    checkOutput("before_async_reset", 4'b1011, 7'h39, 1'b1);
    #1 HRESETn = 1'b0;
    #1;
    checkOutput("async_reset", 4'b1111, 7'h00, 1'b0);
    checkVal("async_reset.HRDATA", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'h0, rd);
    checkVal("reset_digit0", rd, 32'h10);
    applyStimulus(1'b0, 3'd4, 32'h0, rd);
    checkVal("reset_ctrl", rd, 32'h0);
    applyStimulus(1'b0, 3'd6, 32'h0, rd);
    checkVal("reset_status", rd, 32'h0);
    waitUntil(6);
    checkOutput("after_reset_dark", 4'b1111, 7'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
